// File: rtl/structure_hazard_seq.sv
// Structural-hazard sequencer for a shared single-port memory: stalls the pipeline
// while a special memory-operand op (LWi/SWi/Add) or a multi-cycle data access holds the port.
module structure_hazard_seq #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rest,
  input  logic       LWi,
  input  logic       SWi,
  input  logic       Add,
  input  logic       MemRead,
  input  logic       MemWrite,
  output logic [1:0] ControllSignals,
  output logic       AluResultMux,
  output logic       PowerFrezePC,
  output logic       FrezePC,
  output logic       FrezeIFID,
  output logic       FlushIFID,
  output logic       FrezeIDEX,
  output logic       SpecialChangeEXMEM,
  output logic       FrezeMEMWB,
  output logic       Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPEC = 2'd1,
    DACC = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SPEC_INIT = CNT_W'(2 * MEM_LAT - 1);
  localparam logic [CNT_W-1:0] DACC_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam bit               LONG_ACC  = (MEM_LAT > 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       opQ;

  logic       specReq;
  logic       dataReq;
  logic [1:0] specSel;

  assign specReq = LWi | SWi | Add;
  assign dataReq = MemRead | MemWrite;

  // LWi outranks SWi outranks Add; 3 means no special op.
  always_comb begin
    specSel = 2'd3;
    if (LWi)      specSel = 2'd2;
    else if (SWi) specSel = 2'd1;
    else if (Add) specSel = 2'd0;
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state <= IDLE;
      cnt   <= '0;
      opQ   <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (specReq) begin
            opQ   <= specSel;
            cnt   <= SPEC_INIT;
            state <= SPEC;
          end else if (dataReq && LONG_ACC) begin
            cnt   <= DACC_INIT;
            state <= DACC;
          end
        end
        SPEC, DACC: begin
          if (cnt == ONE) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // IDLE decodes the live inputs; the busy states look only at state, cnt and opQ.
  always_comb begin
    ControllSignals    = 2'd3;
    AluResultMux       = 1'b1;
    PowerFrezePC       = 1'b0;
    FrezePC            = 1'b0;
    FrezeIFID          = 1'b0;
    FlushIFID          = 1'b0;
    FrezeIDEX          = 1'b0;
    SpecialChangeEXMEM = 1'b0;
    FrezeMEMWB         = 1'b0;
    Busy               = 1'b0;
    if (!rest) begin
      case (state)
        IDLE: begin
          if (specReq) begin
            ControllSignals = specSel;
            AluResultMux    = 1'b0;
            PowerFrezePC    = 1'b1;
            FrezePC         = 1'b1;
            FrezeIFID       = 1'b1;
            FrezeIDEX       = 1'b1;
            FrezeMEMWB      = 1'b1;
          end else if (dataReq) begin
            FrezePC   = 1'b1;
            FlushIFID = 1'b1;
          end
        end
        SPEC: begin
          ControllSignals    = opQ;
          AluResultMux       = 1'b0;
          PowerFrezePC       = 1'b1;
          FrezePC            = 1'b1;
          FrezeIFID          = 1'b1;
          FrezeIDEX          = 1'b1;
          FrezeMEMWB         = 1'b1;
          SpecialChangeEXMEM = (cnt == ONE);
          Busy               = 1'b1;
        end
        DACC: begin
          FrezePC    = 1'b1;
          FrezeIFID  = 1'b1;
          FrezeIDEX  = 1'b1;
          FrezeMEMWB = 1'b1;
          Busy       = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_structure_hazard_seq.sv
// Bench for structure_hazard_seq: three instances (MEM_LAT 1,2,3) share one stimulus stream
// and are checked against an occupancy-window model, a directed table and corner sequences.
module tb_structure_hazard_seq;

  // Output vector: {CS[1:0], Alu, PowerFrezePC, FrezePC, FrezeIFID, FlushIFID,
  //                 FrezeIDEX, SpecialChangeEXMEM, FrezeMEMWB, Busy}
  localparam logic [10:0] DEF_OUT  = 11'b11_1_0_0_0_0_0_0_0_0;
  localparam logic [10:0] DATA_DET = 11'b11_1_0_1_0_1_0_0_0_0;
  localparam logic [10:0] DACC_OUT = 11'b11_1_0_1_1_0_1_0_1_1;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] RST  = 6'b100000;
  localparam logic [5:0] LW   = 6'b010000;
  localparam logic [5:0] SW   = 6'b001000;
  localparam logic [5:0] AD   = 6'b000100;
  localparam logic [5:0] MR   = 6'b000010;
  localparam logic [5:0] MW   = 6'b000001;

  logic clk = 1'b0;
  logic rest = 1'b1;
  logic LWi = 1'b0, SWi = 1'b0, Add = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
  logic [10:0] outv [3];
  logic [10:0] lastOut [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [1:0] cs;
    logic alu, pfp, fpc, fifid, flush, fidex, sce, fmemwb, busy;
    structure_hazard_seq #(.MEM_LAT(g + 1), .CNT_W(5)) dut (
      .clk(clk), .rest(rest), .LWi(LWi), .SWi(SWi), .Add(Add),
      .MemRead(MemRead), .MemWrite(MemWrite),
      .ControllSignals(cs), .AluResultMux(alu), .PowerFrezePC(pfp),
      .FrezePC(fpc), .FrezeIFID(fifid), .FlushIFID(flush), .FrezeIDEX(fidex),
      .SpecialChangeEXMEM(sce), .FrezeMEMWB(fmemwb), .Busy(busy)
    );
    assign outv[g] = {cs, alu, pfp, fpc, fifid, flush, fidex, sce, fmemwb, busy};
  end

  int checks = 0;
  int errors = 0;

  // Model: each instance owns the port up to and including cycle endCyc.
  int         cyc = 0;
  int         kind [3];
  int         endCyc [3];
  logic [1:0] opSel [3];

  function automatic logic [10:0] specOut(logic [1:0] op, logic chg, logic bsy);
    return {op, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, chg, 1'b1, bsy};
  endfunction

  function automatic logic [1:0] selOf(logic [5:0] inp);
    if (inp[4]) return 2'd2;
    if (inp[3]) return 2'd1;
    if (inp[2]) return 2'd0;
    return 2'd3;
  endfunction

  function automatic logic [10:0] modelOut(int i, logic [5:0] inp);
    if (inp[5]) return DEF_OUT;
    if (cyc <= endCyc[i]) begin
      if (kind[i] == 1) return specOut(opSel[i], cyc == endCyc[i], 1'b1);
      return DACC_OUT;
    end
    if (|inp[4:2]) return specOut(selOf(inp), 1'b0, 1'b0);
    if (|inp[1:0]) return DATA_DET;
    return DEF_OUT;
  endfunction

  task automatic modelEdge(logic [5:0] inp);
    for (int i = 0; i < 3; i++) begin
      if (inp[5]) begin
        endCyc[i] = -1;
        kind[i]   = 0;
      end else if (cyc > endCyc[i]) begin
        if (|inp[4:2]) begin
          kind[i]   = 1;
          opSel[i]  = selOf(inp);
          endCyc[i] = cyc + 2 * (i + 1) - 1;
        end else if (|inp[1:0]) begin
          kind[i]   = 2;
          endCyc[i] = cyc + (i + 1) - 1;
        end
      end
    end
  endtask

  task automatic chk(string name, logic [10:0] act, logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b", name, act, exp);
    end
  endtask

  task automatic step(logic [5:0] inp, bit useExp, logic [10:0] exp2, string tag);
    {rest, LWi, SWi, Add, MemRead, MemWrite} = inp;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      lastOut[i] = outv[i];
      chk($sformatf("%s_lat%0d", tag, i + 1), outv[i], modelOut(i, inp));
    end
    if (useExp) chk({tag, "_tbl"}, outv[1], exp2);
    @(posedge clk);
    modelEdge(inp);
    cyc++;
    #1;
  endtask

  typedef struct {
    logic [5:0]  inp;
    logic [10:0] exp;
  } vec_t;
  vec_t tbl [21];

  initial begin
    int pfCnt;
    int sceAt;
    for (int i = 0; i < 3; i++) begin
      kind[i] = 0; endCyc[i] = -1; opSel[i] = 2'd3;
    end

    // Table expectations are for the MEM_LAT=2 instance.
    tbl[0]  = '{LW,      specOut(2'd2, 1'b0, 1'b0)};
    tbl[1]  = '{NONE,    specOut(2'd2, 1'b0, 1'b1)};
    tbl[2]  = '{LW,      specOut(2'd2, 1'b0, 1'b1)};
    tbl[3]  = '{NONE,    specOut(2'd2, 1'b1, 1'b1)};
    tbl[4]  = '{NONE,    DEF_OUT};
    tbl[5]  = '{MR,      DATA_DET};
    tbl[6]  = '{MR,      DACC_OUT};
    tbl[7]  = '{NONE,    DEF_OUT};
    tbl[8]  = '{LW | AD, specOut(2'd2, 1'b0, 1'b0)};
    tbl[9]  = '{AD,      specOut(2'd2, 1'b0, 1'b1)};
    tbl[10] = '{AD,      specOut(2'd2, 1'b0, 1'b1)};
    tbl[11] = '{AD,      specOut(2'd2, 1'b1, 1'b1)};
    tbl[12] = '{AD,      specOut(2'd0, 1'b0, 1'b0)};
    tbl[13] = '{NONE,    specOut(2'd0, 1'b0, 1'b1)};
    tbl[14] = '{NONE,    specOut(2'd0, 1'b0, 1'b1)};
    tbl[15] = '{NONE,    specOut(2'd0, 1'b1, 1'b1)};
    tbl[16] = '{SW | MW, specOut(2'd1, 1'b0, 1'b0)};
    tbl[17] = '{MR,      specOut(2'd1, 1'b0, 1'b1)};
    tbl[18] = '{NONE,    specOut(2'd1, 1'b0, 1'b1)};
    tbl[19] = '{NONE,    specOut(2'd1, 1'b1, 1'b1)};
    tbl[20] = '{NONE,    DEF_OUT};

    // Reset held with requests present: defaults regardless of inputs.
    step(RST | LW | MR, 1'b1, DEF_OUT, "rst_lw");
    step(RST | SW | MW, 1'b1, DEF_OUT, "rst_sw");
    step(RST | AD,      1'b1, DEF_OUT, "rst_add");

    for (int k = 0; k < 21; k++) step(tbl[k].inp, 1'b1, tbl[k].exp, $sformatf("tbl%0d", k));

    // MEM_LAT=1: special op beats a simultaneous write, then a lone read is a one-cycle flush.
    for (int k = 0; k < 6; k++) step(NONE, 1'b0, DEF_OUT, "gap");
    step(SW | MW, 1'b0, DEF_OUT, "l1_sw");
    chk("l1_sw_cs",    {9'd0, lastOut[0][10:9]}, 11'd1);
    chk("l1_sw_flush", {10'd0, lastOut[0][4]},   11'd0);
    step(NONE, 1'b0, DEF_OUT, "l1_sw_end");
    chk("l1_end_cs",   {9'd0, lastOut[0][10:9]}, 11'd1);
    chk("l1_end_sce",  {10'd0, lastOut[0][2]},   11'd1);
    step(MR, 1'b0, DEF_OUT, "l1_mr");
    chk("l1_mr_out",   lastOut[0], DATA_DET);
    step(NONE, 1'b0, DEF_OUT, "l1_mr_end");
    chk("l1_mr_after", lastOut[0], DEF_OUT);

    // MEM_LAT=3: reset two cycles into SPEC aborts, then a fresh 6-cycle sequence.
    for (int k = 0; k < 6; k++) step(NONE, 1'b0, DEF_OUT, "gap");
    step(LW,   1'b0, DEF_OUT, "l3_lw");
    step(NONE, 1'b0, DEF_OUT, "l3_s1");
    step(NONE, 1'b0, DEF_OUT, "l3_s2");
    step(RST,  1'b0, DEF_OUT, "l3_rst");
    chk("l3_rst_out", lastOut[2], DEF_OUT);
    pfCnt = 0;
    sceAt = -1;
    for (int k = 0; k < 3; k++) begin
      step(NONE, 1'b0, DEF_OUT, "l3_post");
      if (lastOut[2][2]) sceAt = 99;
    end
    chk("l3_no_sce", {10'd0, sceAt == 99}, 11'd0);
    for (int k = 0; k < 7; k++) begin
      step(k == 0 ? LW : NONE, 1'b0, DEF_OUT, "l3_fresh");
      if (lastOut[2][7]) pfCnt++;
      if (lastOut[2][2]) sceAt = k;
    end
    chk("l3_occupancy", 11'(pfCnt), 11'd6);
    chk("l3_sce_cycle", 11'(sceAt), 11'd5);

    // Random traffic against the model on all three latencies.
    for (int k = 0; k < 600; k++) begin
      logic [5:0] inp;
      inp = NONE;
      if ($urandom_range(0, 49) == 0) inp[5] = 1'b1;
      if ($urandom_range(0, 5) == 0) inp[4] = 1'b1;
      if ($urandom_range(0, 5) == 0) inp[3] = 1'b1;
      if ($urandom_range(0, 5) == 0) inp[2] = 1'b1;
      if ($urandom_range(0, 3) == 0) inp[1] = 1'b1;
      if ($urandom_range(0, 3) == 0) inp[0] = 1'b1;
      step(inp, 1'b0, DEF_OUT, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
